v_update_arb: RTL and testbench

//  Upstream feeder of the list-update pipe. Accepts update commands from
//  N_PROD producers over per-producer valid/ready handshakes, buffers each in
//  a small FIFO, and round-robin arbitrates one command per cycle onto the

---
 rtl/v_update_arb_pkg.sv | 32 +++
 rtl/v_update_arb_fifo.sv | 60 ++++++
 rtl/v_update_arb.sv | 126 ++++++++++++
 tb/tb_v_update_arb.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/v_update_arb_pkg.sv
// Shared types and constants for the list-update arbiter.
// Defines the producer count and per-producer FIFO depth, the payload field
// types carried on the update bus, and the upd_t bundle. upd_t is both the
// FIFO entry and the bus payload.
package v_update_arb_pkg;

   localparam int V_UPD_N_PROD     = 4;
   localparam int V_UPD_FIFO_DEPTH = 4;

   localparam int CMD_W  = 2;
   localparam int KEY_W  = 16;
   localparam int SIZE_W = 8;
   localparam int ID_W   = $clog2(V_UPD_N_PROD);

   typedef enum logic [CMD_W-1:0] {
      CMD_INSERT = 2'd0,
      CMD_DELETE = 2'd1,
      CMD_MODIFY = 2'd2,
      CMD_FLUSH  = 2'd3
   } cmd_t;

   typedef logic [KEY_W-1:0]  key_t;
   typedef logic [SIZE_W-1:0] size_t;
   typedef logic [ID_W-1:0]   id_t;

   typedef struct packed {
      cmd_t  cmd;
      key_t  key;
      size_t size;
   } upd_t;

endpackage

// File: rtl/v_update_arb_fifo.sv
// Single-clock synchronous FIFO of upd_t entries. There is one per producer.
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   push, pop     write / read strobes. The caller never pushes when full
//                 and never pops when empty.
//   din           entry to write
//   head          oldest entry; valid whenever !empty
//   full, empty   status decoded from the registered occupancy count
module v_update_arb_fifo
   import v_update_arb_pkg::*;
#(
   parameter int DEPTH = V_UPD_FIFO_DEPTH
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  upd_t din,
   output upd_t head,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   upd_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   // The pointers wrap naturally because DEPTH is a power of two.
   // A push and a pop in the same cycle leave the count unchanged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // The storage has no reset. Reset empties the FIFO through the pointers
   // and the count, so stale contents are never read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

endmodule

// File: rtl/v_update_arb.sv
// Upstream feeder of the list-update pipe. Each producer's command is
// buffered in its own FIFO. One command per cycle is selected round-robin
// and driven onto the registered update bus. The bus has no backpressure.
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   i_prod_vld         per-producer command valid
//   o_prod_rdy         per-producer ready. Derived only from registered
//                      state; it is 0 in reset and in the first cycle
//                      after release.
//   i_prod_cmd/key/size  per-producer payload, flattened producer-major
//   o_upd_vld          update bus valid
//   o_upd_prod_id      producer that originated the current beat
//   o_upd_cmd/key/size payload, passed through unmodified
//   o_idle             all FIFOs empty and no beat on the bus
module v_update_arb
   import v_update_arb_pkg::*;
#(
   parameter int N_PROD     = V_UPD_N_PROD,
   parameter int FIFO_DEPTH = V_UPD_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_PROD-1:0]        i_prod_vld,
   output logic [N_PROD-1:0]        o_prod_rdy,
   input  logic [N_PROD*CMD_W-1:0]  i_prod_cmd,
   input  logic [N_PROD*KEY_W-1:0]  i_prod_key,
   input  logic [N_PROD*SIZE_W-1:0] i_prod_size,
   output logic                     o_upd_vld,
   output logic [ID_W-1:0]          o_upd_prod_id,
   output logic [CMD_W-1:0]         o_upd_cmd,
   output logic [KEY_W-1:0]         o_upd_key,
   output logic [SIZE_W-1:0]        o_upd_size,
   output logic                     o_idle
);

   localparam int SUM_W = ID_W + 1;

   logic [N_PROD-1:0] full;
   logic [N_PROD-1:0] empty;
   logic [N_PROD-1:0] push;
   logic [N_PROD-1:0] pop;
   upd_t              head [N_PROD];

   logic              accept_en;
   id_t               rr_ptr;
   logic              grant;
   id_t               winner;
   id_t               rr_next;
   logic [SUM_W-1:0]  sum;
   id_t               idx;

   assign push = i_prod_vld & o_prod_rdy;

   for (genvar p = 0; p < N_PROD; p++) begin : g_fifo
      upd_t din;
      assign din.cmd  = cmd_t'(i_prod_cmd[p*CMD_W +: CMD_W]);
      assign din.key  = i_prod_key[p*KEY_W +: KEY_W];
      assign din.size = i_prod_size[p*SIZE_W +: SIZE_W];

      v_update_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push[p]),
         .pop   (pop[p]),
         .din   (din),
         .head  (head[p]),
         .full  (full[p]),
         .empty (empty[p])
      );
   end

   // Ready stays low for one cycle after reset release, so producers that
   // held valid through reset are not accepted on the release edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) accept_en <= 1'b0;
      else      accept_en <= 1'b1;
   end

   assign o_prod_rdy = {N_PROD{accept_en}} & ~full;

   // Rotating-priority select: scan offsets from the high end down, so the
   // non-empty FIFO closest at or after rr_ptr is written last and wins.
   always_comb begin
      grant  = 1'b0;
      winner = '0;
      sum    = '0;
      idx    = '0;
      pop    = '0;
      for (int i = N_PROD - 1; i >= 0; i--) begin
         sum = {1'b0, rr_ptr} + SUM_W'(i);
         if (sum >= SUM_W'(N_PROD)) sum = sum - SUM_W'(N_PROD);
         idx = sum[ID_W-1:0];
         if (!empty[idx]) begin
            grant  = 1'b1;
            winner = idx;
         end
      end
      if (grant) pop[winner] = 1'b1;
      rr_next = (winner == id_t'(N_PROD - 1)) ? '0 : winner + 1'b1;
   end

   // The winner's head is captured into the bus flops on the same edge it
   // is popped. When nothing is granted, valid drops and the payload holds.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr        <= '0;
         o_upd_vld     <= 1'b0;
         o_upd_prod_id <= '0;
         o_upd_cmd     <= '0;
         o_upd_key     <= '0;
         o_upd_size    <= '0;
      end else begin
         o_upd_vld <= grant;
         if (grant) begin
            rr_ptr        <= rr_next;
            o_upd_prod_id <= winner;
            o_upd_cmd     <= head[winner].cmd;
            o_upd_key     <= head[winner].key;
            o_upd_size    <= head[winner].size;
         end
      end
   end

   assign o_idle = (&empty) & ~o_upd_vld;

endmodule

// File: tb/tb_v_update_arb.sv
// Testbench for v_update_arb. A queue-per-producer reference model predicts
// ready, the bus beat and idle for every cycle. Directed checks cover reset,
// latency, round-robin order, fairness under full load and reset mid-stream.
// A randomized traffic phase completes the run.
module tb_v_update_arb;
   import v_update_arb_pkg::*;

   localparam int NP    = V_UPD_N_PROD;
   localparam int DEPTH = V_UPD_FIFO_DEPTH;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NP-1:0]        prod_vld;
   logic [NP-1:0]        prod_rdy;
   logic [NP*CMD_W-1:0]  prod_cmd;
   logic [NP*KEY_W-1:0]  prod_key;
   logic [NP*SIZE_W-1:0] prod_size;
   logic                 upd_vld;
   logic [ID_W-1:0]      upd_prod_id;
   logic [CMD_W-1:0]     upd_cmd;
   logic [KEY_W-1:0]     upd_key;
   logic [SIZE_W-1:0]    upd_size;
   logic                 idle;

   always #5 clk = ~clk;

   v_update_arb dut (
      .clk           (clk),
      .rst           (rst),
      .i_prod_vld    (prod_vld),
      .o_prod_rdy    (prod_rdy),
      .i_prod_cmd    (prod_cmd),
      .i_prod_key    (prod_key),
      .i_prod_size   (prod_size),
      .o_upd_vld     (upd_vld),
      .o_upd_prod_id (upd_prod_id),
      .o_upd_cmd     (upd_cmd),
      .o_upd_key     (upd_key),
      .o_upd_size    (upd_size),
      .o_idle        (idle)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: the commands waiting for each producer, the next
   // producer to favour, and the beat currently expected on the bus.
   upd_t          mq [NP][$];
   int            m_rr;
   logic          m_en;
   logic          m_vld;
   id_t           m_id;
   upd_t          m_last;
   logic [NP-1:0] last_acc;

   function automatic logic [NP-1:0] model_rdy();
      logic [NP-1:0] r;
      for (int p = 0; p < NP; p++) r[p] = m_en && (mq[p].size() < DEPTH);
      return r;
   endfunction

   function automatic logic model_idle();
      logic e;
      e = !m_vld;
      for (int p = 0; p < NP; p++) if (mq[p].size() != 0) e = 1'b0;
      return e;
   endfunction

   task automatic model_reset();
      for (int p = 0; p < NP; p++) mq[p].delete();
      m_rr     = 0;
      m_en     = 1'b0;
      m_vld    = 1'b0;
      m_id     = '0;
      m_last   = '0;
      last_acc = '0;
   endtask

   function automatic upd_t drive_payload(input int p);
      upd_t u;
      u.cmd  = cmd_t'(prod_cmd[p*CMD_W +: CMD_W]);
      u.key  = prod_key[p*KEY_W +: KEY_W];
      u.size = prod_size[p*SIZE_W +: SIZE_W];
      return u;
   endfunction

   task automatic set_prod(input int p, input logic v, input upd_t u);
      prod_vld[p]                  = v;
      prod_cmd[p*CMD_W +: CMD_W]   = u.cmd;
      prod_key[p*KEY_W +: KEY_W]   = u.key;
      prod_size[p*SIZE_W +: SIZE_W] = u.size;
   endtask

   function automatic upd_t mk(input int c, input int k, input int s);
      upd_t u;
      u.cmd  = cmd_t'(c[CMD_W-1:0]);
      u.key  = key_t'(k);
      u.size = size_t'(s);
      return u;
   endfunction

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      assert (act === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checkOutput();
      check_val("rdy",  32'(prod_rdy),    32'(model_rdy()));
      check_val("vld",  32'(upd_vld),     32'(m_vld));
      check_val("id",   32'(upd_prod_id), 32'(m_id));
      check_val("cmd",  32'(upd_cmd),     32'(m_last.cmd));
      check_val("key",  32'(upd_key),     32'(m_last.key));
      check_val("size", 32'(upd_size),    32'(m_last.size));
      check_val("idle", 32'(idle),        32'(model_idle()));
   endtask

   // One clock: the model takes the edge with the inputs the bench is
   // driving, then the outputs are compared on the following falling edge.
   task automatic applyStimulus();
      logic [NP-1:0] rdy_before;
      int            w;
      bit            found;
      int            c;
      rdy_before = model_rdy();
      @(posedge clk);
      if (rst) begin
         found = 0;
         w     = 0;
         for (int i = 0; i < NP; i++) begin
            c = (m_rr + i) % NP;
            if (!found && mq[c].size() != 0) begin
               found = 1;
               w     = c;
            end
         end
         m_vld = found;
         if (found) begin
            m_last = mq[w].pop_front();
            m_id   = id_t'(w);
            m_rr   = (w + 1) % NP;
         end
         for (int p = 0; p < NP; p++)
            if (prod_vld[p] && rdy_before[p]) mq[p].push_back(drive_payload(p));
         last_acc = prod_vld & rdy_before;
         m_en     = 1'b1;
      end else begin
         last_acc = '0;
      end
      @(negedge clk);
      checkOutput();
   endtask

   task automatic drain(input int limit);
      for (int p = 0; p < NP; p++) set_prod(p, 1'b0, mk(0, 0, 0));
      for (int i = 0; i < limit && !model_idle(); i++) applyStimulus();
      check_val("drain_idle", 32'(idle), 32'(1));
   endtask

   int            seq [NP];
   int            grant_cnt [NP];
   logic [NP-1:0] full_seen;
   int            stale_hits;
   logic [NP-1:0] cur_vld;
   upd_t          cur_pay [NP];

   initial begin
      prod_vld  = '0;
      prod_cmd  = '0;
      prod_key  = '0;
      prod_size = '0;
      rst       = 1'b0;
      model_reset();

      // Reset held with every producer presenting: nothing ready, bus quiet.
      for (int p = 0; p < NP; p++) set_prod(p, 1'b1, mk(p, 'h20 + p, p + 1));
      repeat (3) applyStimulus();
      rst = 1'b1;
      #1 checkOutput();
      applyStimulus();
      check_val("rst_rdy_after_release", 32'(prod_rdy), 32'hF);
      check_val("rst_none_accepted", 32'(idle), 32'(1));
      applyStimulus();
      for (int p = 0; p < NP; p++) set_prod(p, 1'b0, mk(0, 0, 0));

      // All four accepted on the same edge drain in order 0,1,2,3.
      for (int i = 0; i < NP; i++) begin
         applyStimulus();
         check_val("all4_id",  32'(upd_prod_id), 32'(i));
         check_val("all4_key", 32'(upd_key),     32'('h20 + i));
      end
      applyStimulus();
      check_val("all4_vld_end",  32'(upd_vld), 32'(0));
      check_val("all4_idle_end", 32'(idle),    32'(1));

      // Producer 2 back-to-back: beats appear two cycles after each accept.
      set_prod(2, 1'b1, mk(1, 'h10, 3));
      applyStimulus();
      set_prod(2, 1'b1, mk(1, 'h11, 3));
      applyStimulus();
      check_val("p2_id0",  32'(upd_prod_id), 32'(2));
      check_val("p2_key0", 32'(upd_key),     32'h10);
      set_prod(2, 1'b1, mk(1, 'h12, 3));
      applyStimulus();
      check_val("p2_key1", 32'(upd_key), 32'h11);
      set_prod(2, 1'b0, mk(0, 0, 0));
      applyStimulus();
      check_val("p2_key2", 32'(upd_key), 32'h12);
      applyStimulus();
      check_val("p2_vld_end", 32'(upd_vld), 32'(0));

      // Producer 2 won last, so producer 3 is ahead of producer 0.
      set_prod(0, 1'b1, mk(2, 'h50, 5));
      set_prod(3, 1'b1, mk(2, 'h53, 5));
      applyStimulus();
      set_prod(0, 1'b0, mk(0, 0, 0));
      set_prod(3, 1'b0, mk(0, 0, 0));
      applyStimulus();
      check_val("rr_first",  32'(upd_prod_id), 32'(3));
      applyStimulus();
      check_val("rr_second", 32'(upd_prod_id), 32'(0));
      drain(10);

      // Continuous load from all producers: fair share and FIFOs fill up.
      for (int p = 0; p < NP; p++) begin
         seq[p]       = 0;
         grant_cnt[p] = 0;
      end
      full_seen = '0;
      for (int cyc = 0; cyc < 68; cyc++) begin
         for (int p = 0; p < NP; p++)
            set_prod(p, 1'b1, mk(p, (p << 12) | seq[p], seq[p]));
         applyStimulus();
         for (int p = 0; p < NP; p++) if (last_acc[p]) seq[p]++;
         if (cyc >= 4) begin
            if (upd_vld) grant_cnt[upd_prod_id]++;
            full_seen = full_seen | ~prod_rdy;
         end
      end
      for (int p = 0; p < NP; p++) begin
         check_val("load_grants", 32'(grant_cnt[p]), 32'(16));
         check_val("load_full",   32'(full_seen[p]), 32'(1));
      end
      drain(40);

      // Queue several commands in FIFO 1, then reset in the middle of a cycle.
      for (int p = 0; p < NP; p++) seq[p] = 0;
      for (int cyc = 0; cyc < 20 && mq[1].size() != 3; cyc++) begin
         for (int p = 0; p < NP; p++)
            set_prod(p, 1'b1, mk(p, (p == 1) ? ('hB000 | seq[p]) : ((p << 12) | seq[p]), 1));
         applyStimulus();
         for (int p = 0; p < NP; p++) if (last_acc[p]) seq[p]++;
      end
      #2 rst = 1'b0;
      model_reset();
      #1 checkOutput();
      check_val("async_vld_drop", 32'(upd_vld), 32'(0));
      for (int p = 0; p < NP; p++) set_prod(p, 1'b0, mk(0, 0, 0));
      repeat (2) applyStimulus();
      rst = 1'b1;

      // Random traffic after release. Producers hold a command until it is
      // accepted, and no new key uses the 0xB prefix marking stale entries.
      stale_hits = 0;
      cur_vld    = '0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         for (int p = 0; p < NP; p++) begin
            if (!cur_vld[p] || last_acc[p]) begin
               cur_vld[p] = ($urandom_range(0, 9) < 6);
               cur_pay[p] = mk(int'($urandom_range(0, 3)),
                               int'({4'($urandom_range(0, 10)), 12'($urandom)}),
                               int'($urandom_range(0, 255)));
            end
            set_prod(p, cur_vld[p], cur_pay[p]);
         end
         applyStimulus();
         if (upd_vld && upd_prod_id == 2'd1 && upd_key[15:12] == 4'hB) stale_hits++;
      end
      check_val("no_stale_keys", 32'(stale_hits), 32'(0));
      drain(40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
